// File: rtl/float_norm.sv
// Iterative normalisation stage for the single-precision add/subtract path:
// one left shift per clock, packs sign/exponent/fraction into an IEEE-754 word.
module float_norm #(
    parameter int MANT_W = 25,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sgn,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [MANT_W-1:0]         in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W-2:0]   out_data,
    output logic                      busy
);

    localparam int FRAC_W = MANT_W - 2;
    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t              state, state_d;
    logic                sgn_q, sgn_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic                inf_q, inf_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [EXP_W-1:0]    exp_inc;

    assign exp_inc = exp_q + EXP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sgn_q  <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            inf_q  <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_d;
            sgn_q  <= sgn_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
            inf_q  <= inf_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        state_d = state;
        sgn_d   = sgn_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        inf_d   = inf_q;
        data_d  = data_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sgn_d   = in_sgn;
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    // Infinity is decided by the exponent as presented, before any shifting
                    inf_d   = (in_exp == '1);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (inf_q) begin
                    data_d  = {sgn_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    state_d = DONE;
                end else if (mant_q == '0) begin
                    data_d  = '0;
                    state_d = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    if (exp_inc == '1)
                        data_d = {sgn_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    else
                        data_d = {sgn_q, exp_inc, mant_q[MANT_W-2:1]};
                    state_d = DONE;
                end else if (mant_q[MANT_W-2]) begin
                    data_d  = {sgn_q, exp_q, mant_q[FRAC_W-1:0]};
                    state_d = DONE;
                end else if (exp_q <= EXP_W'(1)) begin
                    data_d  = {sgn_q, {(EXP_W+FRAC_W){1'b0}}};
                    state_d = DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_float_norm.sv
// Directed-vector bench for float_norm: result value, latency, backpressure and async reset.
module tb_float_norm;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sgn;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    float_norm #(.MANT_W(25), .EXP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sgn    (in_sgn),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Present one input, accept it at E0, then count edges until out_valid.
    task automatic start(input logic s, input logic [7:0] e, input logic [24:0] m);
        in_sgn   = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp_data,
                               input int exp_lat, output int lat);
        logic ready_seen;
        ready_seen = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_rdy_low"}, {31'h0, ready_seen | in_ready}, 32'h0);
    endtask

    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [24:0] m, input logic [31:0] exp_data,
                           input int exp_lat);
        int lat;
        start(s, e, m);
        wait_result(tag, exp_data, exp_lat, lat);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {30'h0, out_valid, busy}, 32'h0);
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        logic        stable;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sgn    = 1'b0;
        in_exp    = 8'h00;
        in_mant   = 25'h0;
        out_ready = 1'b1;
        #12;
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data",  out_data, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_vec("norm",     1'b0, 8'h80, 25'h0C00000, 32'h40400000, 1);
        run_vec("carry",    1'b0, 8'h7F, 25'h1800000, 32'h40400000, 1);
        run_vec("ovf",      1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1);
        run_vec("lshift",   1'b0, 8'h80, 25'h0200000, 32'h3F000000, 3);
        run_vec("zero",     1'b1, 8'h80, 25'h0000000, 32'h00000000, 1);
        run_vec("uflow",    1'b1, 8'h02, 25'h0000001, 32'h80000000, 2);
        run_vec("inf_in",   1'b1, 8'hFF, 25'h0000123, 32'hFF800000, 1);
        run_vec("exp0",     1'b0, 8'h00, 25'h0400000, 32'h00000000, 1);
        run_vec("neg_norm", 1'b1, 8'h81, 25'h0A00000, 32'hC0A00000, 1);

        // Backpressure: hold result for 5 cycles, then release with a second input waiting
        out_ready = 1'b0;
        start(1'b0, 8'h80, 25'h0C00000);
        wait_result("bp", 32'h40400000, 1, lat);
        held   = out_data;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_data !== held || !out_valid || in_ready) stable = 1'b0;
        end
        check("bp_stable", {31'h0, stable}, 32'h1);
        out_ready = 1'b1;
        in_sgn    = 1'b1;
        in_exp    = 8'h7F;
        in_mant   = 25'h1800000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {29'h0, in_ready, out_valid, busy}, 32'h4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept", {31'h0, busy}, 32'h1);
        wait_result("bp2", 32'hC0400000, 1, lat);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a left-shift normalisation
        start(1'b0, 8'h80, 25'h0200000);
        @(posedge clk);
        #2;
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_out", {30'h0, out_valid, in_ready}, 32'h1);
        check("arst_data", out_data, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec("post_rst", 1'b0, 8'h80, 25'h0200000, 32'h3F000000, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
